// File: rtl/muldiv_pkg.sv
// Shared constants and decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    // M-extension operation select (funct3 field)
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Controller state encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // rs1 is treated as two's complement for these ops
    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is treated as two's complement for these ops
    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // Upper half of the funct3 space is the divide family
    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: a shift-add multiply bit or a restoring divide bit.
// Multiply: {hi,lo} is {partial product, remaining multiplier}, opd is the multiplicand.
// Divide:   {hi,lo} is {partial remainder, dividend/quotient}, opd is the divisor.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opd_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Compute both iteration flavours and pick the one selected by the op family
    always_comb begin
        sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opd_i} : {(XLEN+1){1'b0}});
        shifted = {hi_i, lo_i[XLEN-1]};
        // shifted < 2*divisor, so bit XLEN of diff is a clean borrow flag
        diff    = shifted - {1'b0, opd_i};
        if (div_i) begin
            if (diff[XLEN]) begin
                hi_o = shifted[XLEN-1:0];
                lo_o = {lo_i[XLEN-2:0], 1'b0};
            end else begin
                hi_o = diff[XLEN-1:0];
                lo_o = {lo_i[XLEN-2:0], 1'b1};
            end
        end else begin
            hi_o = sum[XLEN:1];
            lo_o = {sum[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/ready/done handshake.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | ready=1, waiting for start
//   CALC   | UNROLL shift-add / restoring-subtract iterations per clock
//   FIX    | sign correction and result-half selection
//   DONE   | done=1 for one cycle, result valid
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int                ITER     = XLEN / UNROLL;
    localparam int                CNT_W    = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(ITER - 1);
    localparam logic [XLEN-1:0]   ONE      = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2*XLEN-1:0] ONE_W    = {{(2*XLEN-1){1'b0}}, 1'b1};

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [2:0]       f3_q,     f3_d;
    logic             neg_q,    neg_d;
    logic [XLEN-1:0]  hi_q,     hi_d;
    logic [XLEN-1:0]  lo_q,     lo_d;
    logic [XLEN-1:0]  opd_q,    opd_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic             a_neg, b_neg, fast;
    logic [XLEN-1:0]  a_mag, b_mag, fast_res;
    logic [XLEN-1:0]  fix_res, div_mag;
    logic [2*XLEN-1:0] prod_fix;

    logic [XLEN-1:0]  hi_c [0:UNROLL];
    logic [XLEN-1:0]  lo_c [0:UNROLL];

    assign ready  = (state_q == S_IDLE);
    assign busy   = ~ready;
    assign done   = (state_q == S_DONE);
    assign result = result_q;

    assign hi_c[0] = hi_q;
    assign lo_c[0] = lo_q;

    for (genvar i = 0; i < UNROLL; i++) begin : g_step
        muldiv_step #(.XLEN(XLEN)) u_step (
            .div_i (f3_q[2]),
            .hi_i  (hi_c[i]),
            .lo_i  (lo_c[i]),
            .opd_i (opd_q),
            .hi_o  (hi_c[i+1]),
            .lo_o  (lo_c[i+1])
        );
    end

    // Operand magnitudes and the divide special cases that skip iteration
    always_comb begin
        a_neg    = is_signed_a(funct3) & op_a[XLEN-1];
        b_neg    = is_signed_b(funct3) & op_b[XLEN-1];
        a_mag    = a_neg ? (~op_a + ONE) : op_a;
        b_mag    = b_neg ? (~op_b + ONE) : op_b;
        fast     = 1'b0;
        fast_res = op_a;
        if (is_div(funct3)) begin
            if (op_b == '0) begin
                fast     = 1'b1;
                fast_res = funct3[1] ? op_a : ALL_ONES;
            end else if (!funct3[0] && (op_a == MIN_NEG) && (op_b == ALL_ONES)) begin
                fast     = 1'b1;
                fast_res = funct3[1] ? '0 : op_a;
            end
        end
    end

    // Final sign fix-up and selection of the architectural result
    always_comb begin
        prod_fix = {hi_q, lo_q};
        if (neg_q) begin
            prod_fix = ~prod_fix + ONE_W;
        end
        div_mag = f3_q[1] ? hi_q : lo_q;
        if (is_div(f3_q)) begin
            fix_res = neg_q ? (~div_mag + ONE) : div_mag;
        end else if (f3_q == F3_MUL) begin
            fix_res = prod_fix[XLEN-1:0];
        end else begin
            fix_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    // Next-state logic for the controller and datapath registers
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opd_d    = opd_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    f3_d  = funct3;
                    // REM takes the dividend's sign; everything else the xor of both
                    neg_d = (is_div(funct3) && funct3[1]) ? a_neg : (a_neg ^ b_neg);
                    cnt_d = CNT_INIT;
                    hi_d  = '0;
                    if (is_div(funct3)) begin
                        lo_d  = a_mag;
                        opd_d = b_mag;
                    end else begin
                        lo_d  = b_mag;
                        opd_d = a_mag;
                    end
                    if (fast) begin
                        state_d  = S_DONE;
                        result_d = fast_res;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d  = hi_c[UNROLL];
                    lo_d  = lo_c[UNROLL];
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = fix_res;
                    state_d  = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opd_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opd_q    <= opd_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: one instance at UNROLL=1, one at UNROLL=4.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] res;
        longint      due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start_s  [2];
    logic [2:0]  f3_s     [2];
    logic [31:0] a_s      [2];
    logic [31:0] b_s      [2];
    logic        flush_s  [2];
    logic        ready_s  [2];
    logic        busy_s   [2];
    logic        done_s   [2];
    logic [31:0] result_s [2];

    longint      cyc;
    int          n_checks;
    int          n_err;
    logic [31:0] last_res [2];
    exp_t        sb0 [$];
    exp_t        sb1 [$];

    muldiv_unit #(.XLEN(32), .UNROLL(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .funct3(f3_s[0]),
        .op_a(a_s[0]), .op_b(b_s[0]), .flush(flush_s[0]),
        .ready(ready_s[0]), .busy(busy_s[0]), .done(done_s[0]), .result(result_s[0])
    );

    muldiv_unit #(.XLEN(32), .UNROLL(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .funct3(f3_s[1]),
        .op_a(a_s[1]), .op_b(b_s[1]), .flush(flush_s[1]),
        .ready(ready_s[1]), .busy(busy_s[1]), .done(done_s[1]), .result(result_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference semantics of the M extension, using 64-bit host arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (f3)
            F3_MUL:    begin p = sa * sb; return p[31:0];  end
            F3_MULH:   begin p = sa * sb; return p[63:32]; end
            F3_MULHSU: begin p = sa * ub; return p[63:32]; end
            F3_MULHU:  begin p = ua * ub; return p[63:32]; end
            F3_DIV: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            F3_DIVU: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            F3_REM: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'h0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return 1'b0;
        if (b == 32'h0) return 1'b1;
        return (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Pop the oldest outstanding expectation for unit u and compare
    task automatic on_done(input int u);
        exp_t e;
        if ((u == 0) ? (sb0.size() == 0) : (sb1.size() == 0)) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_done u%0d: got done=1 at cycle %0d, required no pulse", u, cyc);
        end else begin
            e = (u == 0) ? sb0.pop_front() : sb1.pop_front();
            chk($sformatf("result_u%0d", u), result_s[u], e.res);
            n_checks++;
            if (cyc != e.due) begin
                n_err++;
                $display("FAIL latency_u%0d: done at cycle %0d, required %0d", u, cyc, e.due);
            end
            last_res[u] = e.res;
        end
    endtask

    // Monitor: done is checked on the falling edge, away from the sampling edge
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst_n && done_s[u] === 1'b1) on_done(u);
        end
    end

    // Called on a falling edge; returns one falling edge after the accept edge
    task automatic issue(input int u, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] req);
        exp_t e;
        int   t;
        t = 0;
        while (ready_s[u] !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("ready_wait_u%0d", u), {31'b0, ready_s[u]}, 32'd1);
        chk($sformatf("held_u%0d", u), result_s[u], last_res[u]);
        start_s[u] = 1'b1;
        f3_s[u]    = f3;
        a_s[u]     = a;
        b_s[u]     = b;
        e.res = req;
        e.due = cyc + (is_fast(f3, a, b) ? 1 : ((u == 0) ? 34 : 10));
        if (u == 0) sb0.push_back(e); else sb1.push_back(e);
        @(negedge clk);
        start_s[u] = 1'b0;
        f3_s[u]    = 3'($urandom);
        a_s[u]     = $urandom;
        b_s[u]     = $urandom;
    endtask

    task automatic wait_idle(input int u);
        int t;
        t = 0;
        while (((u == 0) ? sb0.size() : sb1.size()) != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_checks++;
            n_err++;
            $display("FAIL drain_timeout_u%0d: outstanding ops remain, required none", u);
            if (u == 0) sb0.delete(); else sb1.delete();
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return $urandom_range(0, 20);
            5: return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          viol;
        logic [2:0]  f3;
        logic [31:0] a, b;
        n_checks = 0;
        n_err    = 0;
        for (int u = 0; u < 2; u++) begin
            start_s[u] = 1'b0; f3_s[u] = 3'b0; a_s[u] = 32'h0; b_s[u] = 32'h0;
            flush_s[u] = 1'b0; last_res[u] = 32'h0;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", {31'b0, ready_s[0]}, 32'd1);
        chk("rst_busy", {31'b0, busy_s[0]}, 32'd0);
        chk("rst_done", {31'b0, done_s[0]}, 32'd0);
        chk("rst_result", result_s[0], 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Headline multiply with busy/ready observed through the whole operation
        issue(0, F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        viol = 0;
        for (int k = 0; k < 40; k++) begin
            if (done_s[0] === 1'b1) break;
            if (!(busy_s[0] === 1'b1 && ready_s[0] === 1'b0)) viol++;
            @(negedge clk);
        end
        chk("busy_window", viol, 32'd0);
        chk("done_ready_low", {31'b0, ready_s[0]}, 32'd0);
        wait_idle(0);

        issue(0, F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000); wait_idle(0);
        issue(0, F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE); wait_idle(0);
        issue(0, F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle(0);
        issue(0, F3_DIV,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD); wait_idle(0);
        issue(0, F3_REM,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF); wait_idle(0);
        issue(0, F3_DIVU,   32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC); wait_idle(0);
        issue(0, F3_REMU,   32'hFFFF_FFF9, 32'd2, 32'd1);         wait_idle(0);
        issue(0, F3_DIV,    32'd5, 32'd0, 32'hFFFF_FFFF);         wait_idle(0);
        issue(0, F3_REMU,   32'd5, 32'd0, 32'd5);                 wait_idle(0);
        issue(0, F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); wait_idle(0);
        issue(0, F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0); wait_idle(0);

        // A start pulse mid-calculation must not disturb the running op
        issue(0, F3_DIVU, 32'd1000, 32'd7, 32'd142);
        repeat (4) @(negedge clk);
        start_s[0] = 1'b1; f3_s[0] = F3_MUL; a_s[0] = 32'd9; b_s[0] = 32'd9;
        @(negedge clk);
        start_s[0] = 1'b0;
        wait_idle(0);

        // Flush in cycle 10 of a divide, then an immediate multiply
        issue(0, F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        repeat (9) @(negedge clk);
        flush_s[0] = 1'b1;
        @(negedge clk);
        flush_s[0] = 1'b0;
        if (sb0.size() > 0) void'(sb0.pop_back());
        chk("flush_ready", {31'b0, ready_s[0]}, 32'd1);
        chk("flush_no_done", {31'b0, done_s[0]}, 32'd0);
        chk("flush_result", result_s[0], last_res[0]);
        issue(0, F3_MUL, 32'd3, 32'd4, 32'd12);
        wait_idle(0);

        // Flush beats start in IDLE
        start_s[0] = 1'b1; flush_s[0] = 1'b1; f3_s[0] = F3_MUL; a_s[0] = 32'd5; b_s[0] = 32'd5;
        @(negedge clk);
        start_s[0] = 1'b0; flush_s[0] = 1'b0;
        chk("flush_start_ready", {31'b0, ready_s[0]}, 32'd1);
        repeat (3) @(negedge clk);

        // UNROLL=4 directed cases
        issue(1, F3_DIVU, 32'd100, 32'd7, 32'd14); wait_idle(1);
        issue(1, F3_REMU, 32'd100, 32'd7, 32'd2);  wait_idle(1);

        // Randomised traffic against the reference model, back-to-back on UNROLL=4
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom); a = rand_opnd(); b = rand_opnd();
            issue(0, f3, a, b, ref_model(f3, a, b));
            wait_idle(0);
        end
        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom); a = rand_opnd(); b = rand_opnd();
            issue(1, f3, a, b, ref_model(f3, a, b));
        end
        wait_idle(1);

        // Asynchronous reset in the middle of a calculation
        issue(0, F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", {31'b0, ready_s[0]}, 32'd1);
        chk("arst_busy", {31'b0, busy_s[0]}, 32'd0);
        chk("arst_done", {31'b0, done_s[0]}, 32'd0);
        chk("arst_result", result_s[0], 32'h0);
        sb0.delete();
        sb1.delete();
        last_res[0] = 32'h0;
        last_res[1] = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(0, F3_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
        wait_idle(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
